// File: rtl/stride_value_predictor.sv
// rtl/stride_value_predictor.sv - PC-indexed last-value + stride load value predictor
module stride_value_predictor #(
    parameter int INDEX_WIDTH    = 6,
    parameter int TAG_WIDTH      = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int CONF_WIDTH     = 2,
    parameter int CONF_THRESHOLD = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  vp_en,
    input  logic                  pred_req,
    input  logic [ADDR_WIDTH-1:0] pred_pc,
    output logic                  resp_valid,
    output logic                  pred_valid,
    output logic [DATA_WIDTH-1:0] pred_data,
    output logic                  busy,
    input  logic                  mem_valid,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  flush,
    output logic                  en_recover,
    output logic                  correct_prediction
);

    localparam int ENTRIES = 1 << INDEX_WIDTH;
    localparam logic [CONF_WIDTH-1:0] CONF_THR = CONF_WIDTH'(CONF_THRESHOLD);
    localparam logic [CONF_WIDTH-1:0] CONF_MAX = '1;

    typedef enum logic [1:0] {IDLE, LOOKUP, PREDICTED, TRAIN} state_t;

    state_t                 state;
    logic [ENTRIES-1:0]     tbl_valid;
    logic [TAG_WIDTH-1:0]   tbl_tag    [ENTRIES];
    logic [DATA_WIDTH-1:0]  tbl_last   [ENTRIES];
    logic [DATA_WIDTH-1:0]  tbl_stride [ENTRIES];
    logic [CONF_WIDTH-1:0]  tbl_conf   [ENTRIES];

    logic [INDEX_WIDTH-1:0] cur_idx;
    logic [TAG_WIDTH-1:0]   cur_tag;

    logic                   hit;
    logic                   confident;
    logic                   train_en;
    logic [DATA_WIDTH-1:0]  pred_value;
    logic [DATA_WIDTH-1:0]  new_stride;
    logic                   unused_pc_bits;

    // Only the index and tag slices of the PC matter; fold the rest away.
    assign unused_pc_bits = ^pred_pc;

    assign hit        = tbl_valid[cur_idx] && (tbl_tag[cur_idx] == cur_tag);
    assign confident  = tbl_conf[cur_idx] >= CONF_THR;
    assign pred_value = tbl_last[cur_idx] + tbl_stride[cur_idx];
    assign new_stride = mem_data - tbl_last[cur_idx];
    assign train_en   = ((state == PREDICTED) || (state == TRAIN)) && mem_valid && !flush;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            resp_valid         <= 1'b0;
            pred_valid         <= 1'b0;
            pred_data          <= '0;
            en_recover         <= 1'b0;
            correct_prediction <= 1'b0;
            cur_idx            <= '0;
            cur_tag            <= '0;
            tbl_valid          <= '0;
        end else begin
            resp_valid         <= 1'b0;
            pred_valid         <= 1'b0;
            en_recover         <= 1'b0;
            correct_prediction <= 1'b0;
            case (state)
                IDLE: begin
                    if (pred_req) begin
                        cur_idx <= pred_pc[INDEX_WIDTH+1:2];
                        cur_tag <= pred_pc[INDEX_WIDTH+TAG_WIDTH+1:INDEX_WIDTH+2];
                        state   <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (hit && confident && vp_en) begin
                        resp_valid <= 1'b1;
                        pred_valid <= 1'b1;
                        pred_data  <= pred_value;
                        state      <= PREDICTED;
                    end else begin
                        resp_valid <= 1'b1;
                        pred_data  <= '0;
                        state      <= TRAIN;
                    end
                end
                PREDICTED, TRAIN: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (mem_valid) begin
                        tbl_valid[cur_idx] <= 1'b1;
                        state              <= IDLE;
                        // pred_data still holds the value handed out in LOOKUP.
                        if (state == PREDICTED) begin
                            correct_prediction <= (mem_data == pred_data);
                            en_recover         <= (mem_data != pred_data);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Payload fields need no reset: they are only trusted behind tbl_valid.
    always_ff @(posedge clk) begin
        if (train_en) begin
            tbl_last[cur_idx] <= mem_data;
            if (!hit) begin
                tbl_tag[cur_idx]    <= cur_tag;
                tbl_stride[cur_idx] <= '0;
                tbl_conf[cur_idx]   <= '0;
            end else if (new_stride == tbl_stride[cur_idx]) begin
                if (tbl_conf[cur_idx] != CONF_MAX)
                    tbl_conf[cur_idx] <= tbl_conf[cur_idx] + 1'b1;
            end else begin
                tbl_stride[cur_idx] <= new_stride;
                tbl_conf[cur_idx]   <= '0;
            end
        end
    end

endmodule
